// File: rtl/muldiv_pkg.sv
// Shared types for the iterative HI/LO multiply/divide engine.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

    // Divide by zero reports a quotient made entirely of this bit.
    localparam logic DIV0_LO_FILL = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// acc holds {hi, lo}: partial product / multiplier, or remainder / quotient.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mag,
    input  op_t                kind,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, mag};
        acc_next = acc;
        unique case (kind)
            OP_MUL: begin
                if (acc[0])
                    acc_next = {sum, acc[WIDTH-1:1]};
                else
                    acc_next = {1'b0, acc[2*WIDTH-1:1]};
            end
            OP_DIV: begin
                // A borrow out of the trial subtract means restore.
                if (!diff[WIDTH])
                    acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide for the HI/LO path, WIDTH steps per op.
// Define MULDIV_UNSIGNED_EN to add op_unsigned for multu/divu.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    state_t             state;
    op_t                kind;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic               neg_res;
    logic               neg_rem;
    logic [CW-1:0]      cnt;
    logic               signed_op;

`ifdef MULDIV_UNSIGNED_EN
    logic uns_q;
    assign signed_op = ~uns_q;
`else
    assign signed_op = 1'b1;
`endif

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // MIN_INT negates to itself, which reads correctly as unsigned 2^(W-1).
    always_comb begin
        abs_a    = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b    = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH]
                           : acc[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc),
        .mag     (mag_b),
        .kind    (kind),
        .acc_next(acc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            kind        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            mag_b       <= '0;
            acc         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_UNSIGNED_EN
            uns_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (mult_start || div_start) begin
                        kind        <= mult_start ? OP_MUL : OP_DIV;
                        a_q         <= op_a;
                        b_q         <= op_b;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= PREP;
`ifdef MULDIV_UNSIGNED_EN
                        uns_q       <= op_unsigned;
`endif
                    end
                end
                PREP: begin
                    mag_b   <= abs_b;
                    acc     <= {{WIDTH{1'b0}}, abs_a};
                    neg_res <= signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem <= signed_op & a_q[WIDTH-1];
                    cnt     <= CNT_INIT;
                    if (kind == OP_DIV && b_q == '0) begin
                        hi_out      <= a_q;
                        lo_out      <= {WIDTH{DIV0_LO_FILL}};
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (kind == OP_MUL) begin
                        hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_out <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi_out <= rem_fix;
                        lo_out <= quo_fix;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed checks of muldiv_sequencer against an arithmetic model.
// Define MULDIV_UNSIGNED_EN to also exercise multu/divu.
module tb_muldiv_sequencer;

    localparam int W      = 32;
    localparam int LAT    = W + 3;
    localparam int LAT_DZ = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mult_start = 1'b0;
    logic         div_start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         op_unsigned = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         div_by_zero;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_a       (op_a),
        .op_b       (op_b),
`ifdef MULDIV_UNSIGNED_EN
        .op_unsigned(op_unsigned),
`endif
        .busy       (busy),
        .done       (done),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .div_by_zero(div_by_zero)
    );

    // Plain-arithmetic reference: 64-bit products and SV truncating division.
    function automatic void model(input bit is_div, input bit uns,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic dz, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        dz  = 1'b0;
        lat = LAT;
        if (uns) begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end else begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
        end
        if (!is_div) begin
            p  = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == '0) begin
            hi  = a;
            lo  = '1;
            dz  = 1'b1;
            lat = LAT_DZ;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    // Drives one start and watches up to 60 cycles; lat is the 1-based
    // cycle index (after the start-sampling edge) where done is first seen.
    task automatic do_op(input logic m, input logic d, input logic u,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inject_at,
                         output int lat, output int ndone, output logic busy1,
                         output logic dz1, output logic [W-1:0] hi,
                         output logic [W-1:0] lo, output logic dz);
        lat   = 0;
        ndone = 0;
        busy1 = 1'b0;
        dz1   = 1'b0;
        hi    = '0;
        lo    = '0;
        dz    = 1'b0;
        @(negedge clk);
        mult_start  = m;
        div_start   = d;
        op_unsigned = u;
        op_a        = a;
        op_b        = b;
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        busy1      = busy;
        dz1        = div_by_zero;
        for (int i = 1; i <= 60; i++) begin
            if (i > 1) @(negedge clk);
            if (i == inject_at) begin
                div_start = 1'b1;
                op_a      = $urandom;
                op_b      = $urandom;
            end else if (i == inject_at + 1) begin
                div_start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = i;
                    hi  = hi_out;
                    lo  = lo_out;
                    dz  = div_by_zero;
                end
            end
            if (lat != 0 && i >= lat + 2) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, div_by_zero, hi_out, lo_out} !== '0)
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                     busy, done, div_by_zero, hi_out, lo_out);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_and_check(input string name, input logic m, input logic d,
                                 input logic u, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        int lat, nd, elat;
        logic b1, z1, dz, edz;
        logic [W-1:0] hi, lo, ehi, elo;
        model(!m && d, u, a, b, ehi, elo, edz, elat);
        do_op(m, d, u, a, b, 0, lat, nd, b1, z1, hi, lo, dz);
        total++;
        if (lat !== elat || nd !== 1 || hi !== ehi || lo !== elo || dz !== edz)
            $display("FAIL %s a=%h b=%h: got lat=%0d n=%0d hi=%h lo=%h dz=%b, want lat=%0d n=1 hi=%h lo=%h dz=%b",
                     name, a, b, lat, nd, hi, lo, dz, elat, ehi, elo, edz);
        else passed++;
    endtask

    task automatic test_mult();
        int lat, nd;
        logic b1, z1, dz;
        logic [W-1:0] hi, lo;
        do_op(1'b1, 1'b0, 1'b0, 32'd7, -32'sd3, 0, lat, nd, b1, z1, hi, lo, dz);
        total++;
        if (b1 !== 1'b1 || lat !== LAT || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB || dz !== 1'b0)
            $display("FAIL mult_7x-3: got busy1=%b lat=%0d hi=%h lo=%h dz=%b, want 1 %0d ffffffff ffffffeb 0",
                     b1, lat, hi, lo, dz, LAT);
        else passed++;
        total++;
        if (busy !== 1'b0)
            $display("FAIL mult_busy_after: got %b want 0", busy);
        else passed++;
        for (int k = 0; k < 12; k++)
            run_and_check("mult_rand", 1'b1, 1'b0, 1'b0, $urandom, $urandom);
        run_and_check("mult_min_x_-1", 1'b1, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    endtask

    task automatic test_div();
        logic [W-1:0] a, b;
        run_and_check("div_-7/2", 1'b0, 1'b1, 1'b0, -32'sd7, 32'd2);
        run_and_check("div_min/-1", 1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        run_and_check("div_small/min", 1'b0, 1'b1, 1'b0, 32'd12345, 32'h80000000);
        for (int k = 0; k < 12; k++) begin
            a = $urandom;
            b = $urandom;
            if (k % 3 == 0) b = b >> $urandom_range(31, 20);
            if (k % 4 == 1) b = -b;
            run_and_check("div_rand", 1'b0, 1'b1, 1'b0, a, b);
        end
    endtask

    task automatic test_div_by_zero();
        int lat, nd;
        logic b1, z1, dz;
        logic [W-1:0] hi, lo;
        do_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 0, lat, nd, b1, z1, hi, lo, dz);
        total++;
        if (lat !== LAT_DZ || nd !== 1 || hi !== 32'd5 || lo !== 32'hFFFFFFFF || dz !== 1'b1)
            $display("FAIL div_by_zero: got lat=%0d n=%0d hi=%h lo=%h dz=%b, want %0d 1 5 ffffffff 1",
                     lat, nd, hi, lo, dz, LAT_DZ);
        else passed++;
        total++;
        if (div_by_zero !== 1'b1)
            $display("FAIL dz_held: got %b want 1", div_by_zero);
        else passed++;
        do_op(1'b1, 1'b0, 1'b0, 32'd3, 32'd4, 0, lat, nd, b1, z1, hi, lo, dz);
        total++;
        if (z1 !== 1'b0 || dz !== 1'b0 || lo !== 32'd12 || hi !== 32'd0)
            $display("FAIL dz_cleared: got dz1=%b dz=%b hi=%h lo=%h, want 0 0 0 c",
                     z1, dz, hi, lo);
        else passed++;
    endtask

    task automatic test_simultaneous();
        int lat, nd;
        logic b1, z1, dz;
        logic [W-1:0] hi, lo;
        do_op(1'b1, 1'b1, 1'b0, 32'h80000000, 32'h80000000, 15,
              lat, nd, b1, z1, hi, lo, dz);
        total++;
        if (lat !== LAT || nd !== 1 || hi !== 32'h40000000 || lo !== 32'h0)
            $display("FAIL mult_wins_ignore_mid: got lat=%0d n=%0d hi=%h lo=%h, want %0d 1 40000000 0",
                     lat, nd, hi, lo, LAT);
        else passed++;
        repeat (5) @(negedge clk);
        total++;
        if (hi_out !== 32'h40000000 || lo_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL result_hold: got hi=%h lo=%h busy=%b done=%b, want 40000000 0 0 0",
                     hi_out, lo_out, busy, done);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        @(negedge clk);
        mult_start = 1'b1;
        op_a       = 32'd1000;
        op_b       = 32'd1000;
        @(negedge clk);
        mult_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({busy, done, hi_out, lo_out} !== '0)
            $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h, want all 0",
                     busy, done, hi_out, lo_out);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0)
            $display("FAIL no_done_after_abort: got %0d active cycles, want 0", seen);
        else passed++;
        run_and_check("after_abort", 1'b1, 1'b0, 1'b0, 32'd1000, 32'd1000);
    endtask

`ifdef MULDIV_UNSIGNED_EN
    task automatic test_unsigned();
        run_and_check("multu_ffff_x2", 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2);
        run_and_check("divu_ffff/16", 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd16);
        run_and_check("divu_by_zero", 1'b0, 1'b1, 1'b1, 32'h80000001, 32'd0);
        for (int k = 0; k < 6; k++) begin
            run_and_check("multu_rand", 1'b1, 1'b0, 1'b1, $urandom, $urandom);
            run_and_check("divu_rand", 1'b0, 1'b1, 1'b1, $urandom, $urandom >> k);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_simultaneous();
        test_reset_abort();
`ifdef MULDIV_UNSIGNED_EN
        test_unsigned();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
